// File: rtl/vga_pkg.sv
// Shared types and reference geometries for the VGA raster timing generator.
package vga_pkg;

  localparam int DEF_WIDTH  = 12;
  localparam int DEF_ADDR_W = 20;

  // 800x600@72, 50 MHz pixel clock, positive syncs
  localparam int V800_HSIZE = 800;
  localparam int V800_HFP   = 856;
  localparam int V800_HSP   = 976;
  localparam int V800_HMAX  = 1040;
  localparam int V800_VSIZE = 600;
  localparam int V800_VFP   = 637;
  localparam int V800_VSP   = 643;
  localparam int V800_VMAX  = 666;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int V640_HSIZE = 640;
  localparam int V640_HFP   = 656;
  localparam int V640_HSP   = 752;
  localparam int V640_HMAX  = 800;
  localparam int V640_VSIZE = 480;
  localparam int V640_VFP   = 490;
  localparam int V640_VSP   = 492;
  localparam int V640_VMAX  = 525;
  localparam bit V640_HSPP  = 1'b0;
  localparam bit V640_VSPP  = 1'b0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator and the display path.
// pix_addr exists only when VGA_TIMING_ADDR_EN is defined.
interface vga_timing_gen_if import vga_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
`ifdef VGA_TIMING_ADDR_EN
  , parameter int ADDR_W = DEF_ADDR_W
`endif
);
  logic             enable;
  logic [WIDTH-1:0] hdata;
  logic [WIDTH-1:0] vdata;
`ifdef VGA_TIMING_ADDR_EN
  logic [ADDR_W-1:0] pix_addr;
`endif
  logic             line_start;
  logic             frame_start;
  logic             hsync;
  logic             vsync;
  logic             data_enable;

  modport master (
    input  enable,
    output hdata, vdata,
`ifdef VGA_TIMING_ADDR_EN
    output pix_addr,
`endif
    output line_start, frame_start, hsync, vsync, data_enable
  );

  modport slave (
    output enable,
    input  hdata, vdata,
`ifdef VGA_TIMING_ADDR_EN
    input  pix_addr,
`endif
    input  line_start, frame_start, hsync, vsync, data_enable
  );
endinterface

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of arbitrary type; DEPTH 0 is a plain wire.
module vga_delay_line #(
  parameter int  DEPTH   = 2,
  parameter type T       = logic,
  parameter T    RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  T     din,
  output T     dout
);
  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      T stage_reg [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= RST_VAL;
        end else if (ce) begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync decode and latency-matched sync/enable outputs.
// Define VGA_TIMING_ADDR_EN to build the linear pix_addr counter.
module vga_timing_gen import vga_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HSIZE = V800_HSIZE,
  parameter int HFP   = V800_HFP,
  parameter int HSP   = V800_HSP,
  parameter int HMAX  = V800_HMAX,
  parameter int VSIZE = V800_VSIZE,
  parameter int VFP   = V800_VFP,
  parameter int VSP   = V800_VSP,
  parameter int VMAX  = V800_VMAX,
  parameter bit HSPP  = 1'b1,
  parameter bit VSPP  = 1'b1,
  parameter int PIPE  = 2
`ifdef VGA_TIMING_ADDR_EN
  , parameter int ADDR_W = DEF_ADDR_W
`endif
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);
  localparam logic [WIDTH-1:0] H_LAST = WIDTH'(HMAX - 1);
  localparam logic [WIDTH-1:0] V_LAST = WIDTH'(VMAX - 1);
  localparam logic [WIDTH-1:0] H_VIS  = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] V_VIS  = WIDTH'(VSIZE);
  localparam logic [WIDTH-1:0] H_FP   = WIDTH'(HFP);
  localparam logic [WIDTH-1:0] H_SP   = WIDTH'(HSP);
  localparam logic [WIDTH-1:0] V_FP   = WIDTH'(VFP);
  localparam logic [WIDTH-1:0] V_SP   = WIDTH'(VSP);
  localparam vga_sync_t SYNC_IDLE = '{hs: ~HSPP, vs: ~VSPP, de: 1'b0};

  generate
    if (!(HSIZE <= HFP && HFP < HSP && HSP <= HMAX)) begin : g_bad_h
      $error("vga_timing_gen: horizontal geometry out of order");
    end
    if (!(VSIZE <= VFP && VFP < VSP && VSP <= VMAX)) begin : g_bad_v
      $error("vga_timing_gen: vertical geometry out of order");
    end
    if ((HMAX >> WIDTH) != 0 || (VMAX >> WIDTH) != 0) begin : g_bad_width
      $error("vga_timing_gen: HMAX/VMAX do not fit in WIDTH bits");
    end
    if (PIPE < 0 || PIPE > 8) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE must be 0..8");
    end
`ifdef VGA_TIMING_ADDR_EN
    if (longint'(HSIZE) * longint'(VSIZE) > (longint'(1) << ADDR_W)) begin : g_bad_addr
      $error("vga_timing_gen: visible area exceeds pix_addr range");
    end
`endif
  endgenerate

  logic [WIDTH-1:0] hdata_reg, hdata_next;
  logic [WIDTH-1:0] vdata_reg, vdata_next;
  logic             h_wrap, v_wrap;
  vga_sync_t        sync0, sync_out;

  always_comb begin
    h_wrap     = (hdata_reg == H_LAST);
    v_wrap     = (vdata_reg == V_LAST);
    hdata_next = h_wrap ? '0 : hdata_reg + WIDTH'(1);
    vdata_next = vdata_reg;
    if (h_wrap) vdata_next = v_wrap ? '0 : vdata_reg + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdata_reg <= '0;
      vdata_reg <= '0;
    end else if (bus.enable) begin
      hdata_reg <= hdata_next;
      vdata_reg <= vdata_next;
    end
  end

  always_comb begin
    sync0    = SYNC_IDLE;
    sync0.hs = (hdata_reg >= H_FP && hdata_reg < H_SP) ? HSPP : ~HSPP;
    sync0.vs = (vdata_reg >= V_FP && vdata_reg < V_SP) ? VSPP : ~VSPP;
    sync0.de = (hdata_reg < H_VIS) && (vdata_reg < V_VIS);
  end

`ifdef VGA_TIMING_ADDR_EN
  localparam logic [WIDTH-1:0] H_VIS_LAST = WIDTH'(HSIZE - 1);
  localparam logic [WIDTH-1:0] V_VIS_LAST = WIDTH'(VSIZE - 1);

  logic [ADDR_W-1:0] pix_addr_reg, pix_addr_next;
  logic              last_pix;

  // The final visible pixel does not advance the address, so it parks at
  // HSIZE*VSIZE-1 through vertical blanking instead of overshooting.
  always_comb begin
    last_pix      = (hdata_reg == H_VIS_LAST) && (vdata_reg == V_VIS_LAST);
    pix_addr_next = pix_addr_reg;
    if (h_wrap && v_wrap)
      pix_addr_next = '0;
    else if (sync0.de && !last_pix)
      pix_addr_next = pix_addr_reg + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      pix_addr_reg <= '0;
    else if (bus.enable)
      pix_addr_reg <= pix_addr_next;
  end

  assign bus.pix_addr = pix_addr_reg;
`endif

  vga_delay_line #(
    .DEPTH   (PIPE),
    .T       (vga_sync_t),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .ce   (bus.enable),
    .din  (sync0),
    .dout (sync_out)
  );

  assign bus.hdata       = hdata_reg;
  assign bus.vdata       = vdata_reg;
  assign bus.line_start  = (hdata_reg == '0);
  assign bus.frame_start = (hdata_reg == '0) && (vdata_reg == '0);
  assign bus.hsync       = sync_out.hs;
  assign bus.vsync       = sync_out.vs;
  assign bus.data_enable = sync_out.de;
endmodule
